// File: rtl/conv_writeback_ctrl_v2_if.sv
// Bus bundle between the writeback controller and its environment.
// The master modport is the controller's view of the bus; the slave modport is
// the view of the PE array, result DMA port and sequencer that surround it.
interface conv_writeback_ctrl_v2_if #(
  parameter int DW      = 32,
  parameter int R       = 14,
  parameter int DEPTH_W = 8
);
  localparam int RW = $clog2(R + 1);

  logic               stall;
  logic               start_init;
  logic [DEPTH_W-1:0] cfg_depth;
  logic [RW-1:0]      cfg_rows;
  logic               p_filter_end;
  logic               end_conv;
  logic [R-1:0]       row_valid;
  logic [DW*R-1:0]    row;
  logic [R-1:0]       p_write_zero;
  logic               p_init;
  logic               start_conv;
  logic               odd_cnt;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               stall_req;
  logic [1:0]         err;
  logic               busy;
  logic               end_op;

  modport master (
    input  stall, start_init, cfg_depth, cfg_rows, p_filter_end, end_conv,
           row_valid, row, out_ready,
    output p_write_zero, p_init, start_conv, odd_cnt, out_data, out_valid,
           stall_req, err, busy, end_op
  );

  modport slave (
    output stall, start_init, cfg_depth, cfg_rows, p_filter_end, end_conv,
           row_valid, row, out_ready,
    input  p_write_zero, p_init, start_conv, odd_cnt, out_data, out_valid,
           stall_req, err, busy, end_op
  );
endinterface

// File: rtl/conv_writeback_ctrl_v2.sv
// Writeback controller for the conv accumulator array.
// Sequences buffer init, conv start, ping-pong swap and a row-by-row drain,
// and funnels row results into an output FIFO with ready/valid backpressure.
// Sequencing outputs are registered from the state, so they trail the state by one cycle.
module conv_writeback_ctrl_v2 #(
  parameter int DW         = 32,
  parameter int R          = 14,
  parameter int DEPTH_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_writeback_ctrl_v2_if.master bus
);
  localparam int RW = $clog2(R + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_START,
    S_WAIT_FILT,
    S_WAIT_ADD,
    S_SWAP,
    S_DRAIN,
    S_GAP,
    S_FINISH,
    S_DONE
  } state_t;

  state_t             st, st_nxt;
  logic [DEPTH_W-1:0] cnt;
  logic [RW-1:0]      k, k_nxt;
  logic [DEPTH_W-1:0] depth_q;
  logic [RW-1:0]      rows_q;
  logic               ec_latch;
  logic               odd_q;
  logic               p_init_q;
  logic               start_conv_q;
  logic [R-1:0]       pwz_q;
  logic               end_op_q;
  logic [1:0]         err_q;

  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic               cnt_last;
  logic               start_accept;
  logic [DW-1:0]      push_data;
  logic               multi_hot;
  logic               push_req, pop, full, push_ok, overflow;

  assign cnt_last     = (cnt == depth_q - DEPTH_W'(1));
  assign start_accept = !bus.stall && (st == S_IDLE) && bus.start_init;

  // Next-state and row-index logic; each timed state counts cnt up to its length
  always_comb begin
    st_nxt = st;
    k_nxt  = k;
    case (st)
      S_IDLE:      if (bus.start_init) st_nxt = S_INIT;
      S_INIT:      if (cnt_last) st_nxt = S_START;
      S_START:     if (cnt == DEPTH_W'(3)) st_nxt = S_WAIT_FILT;
      S_WAIT_FILT: if (bus.p_filter_end) st_nxt = S_WAIT_ADD;
      S_WAIT_ADD:  if (cnt_last) st_nxt = S_SWAP;
      S_SWAP:      st_nxt = S_DRAIN;
      S_DRAIN: begin
        if (cnt_last) begin
          if (k == rows_q - RW'(1)) begin
            k_nxt  = '0;
            st_nxt = ec_latch ? S_FINISH : S_WAIT_FILT;
          end else begin
            k_nxt  = k + RW'(1);
            st_nxt = S_GAP;
          end
        end
      end
      S_GAP:       st_nxt = S_DRAIN;
      S_FINISH:    if (count == '0) st_nxt = S_DONE;
      S_DONE:      st_nxt = S_IDLE;
      default:     st_nxt = S_IDLE;
    endcase
  end

  // State, cycle counter, row index and latched config; all frozen by stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cnt     <= '0;
      k       <= '0;
      depth_q <= DEPTH_W'(1);
      rows_q  <= RW'(R);
    end else if (!bus.stall) begin
      st  <= st_nxt;
      cnt <= (st_nxt != st) ? '0 : cnt + DEPTH_W'(1);
      k   <= k_nxt;
      if (start_accept) begin
        depth_q <= (bus.cfg_depth == '0) ? DEPTH_W'(1) : bus.cfg_depth;
        rows_q  <= ((bus.cfg_rows == '0) || (bus.cfg_rows > RW'(R))) ? RW'(R) : bus.cfg_rows;
      end
    end
  end

  // Registered sequencing outputs derived from the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_init_q     <= 1'b0;
      start_conv_q <= 1'b0;
      pwz_q        <= '0;
      end_op_q     <= 1'b0;
      odd_q        <= 1'b0;
    end else if (!bus.stall) begin
      p_init_q     <= (st == S_INIT);
      start_conv_q <= (st == S_START) || (st == S_SWAP);
      pwz_q        <= (st == S_DRAIN) ? ({{(R-1){1'b0}}, 1'b1} << k) : '0;
      end_op_q     <= (st == S_DONE);
      if (st == S_SWAP) odd_q <= ~odd_q;
    end
  end

  // Last-pass marker: captured whenever seen, consumed once the op reaches FINISH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec_latch <= 1'b0;
    else if (st == S_FINISH) ec_latch <= 1'b0;
    else if (bus.end_conv) ec_latch <= 1'b1;
  end

  // Priority pick of the lowest-index valid row for the FIFO write
  always_comb begin
    push_data = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (bus.row_valid[i]) push_data = bus.row[i*DW +: DW];
    end
  end

  assign multi_hot = (bus.row_valid & (bus.row_valid - R'(1))) != '0;
  assign push_req  = !bus.stall && (bus.row_valid != '0);
  assign pop       = bus.out_valid && bus.out_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push_ok   = push_req && (!full || pop);
  assign overflow  = push_req && full && !pop;

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, wiped when a new op is accepted; fresh errors still land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 2'b00;
    else err_q <= (start_accept ? 2'b00 : err_q) | {overflow, push_req && multi_hot};
  end

  assign bus.p_init       = p_init_q;
  assign bus.start_conv   = start_conv_q;
  assign bus.p_write_zero = pwz_q;
  assign bus.odd_cnt      = odd_q;
  assign bus.end_op       = end_op_q;
  assign bus.err          = err_q;
  assign bus.busy         = (st != S_IDLE);
  assign bus.out_valid    = (count != '0);
  assign bus.out_data     = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.stall_req    = (count >= CW'(FIFO_DEPTH - AF_MARGIN));
endmodule

// File: tb/tb_conv_writeback_ctrl_v2.sv
// Bench for conv_writeback_ctrl_v2: directed scenarios with literal expectations,
// then a long randomized run, all checked every cycle against a phase/queue model.
module tb_conv_writeback_ctrl_v2;
  localparam int DW = 32;
  localparam int R = 14;
  localparam int DEPTH_W = 8;
  localparam int FD = 16;
  localparam int AFM = 4;
  localparam int RW = $clog2(R + 1);

  localparam int PH_IDLE = 0, PH_INIT = 1, PH_START = 2, PH_WFILT = 3, PH_WADD = 4;
  localparam int PH_SWAP = 5, PH_DRAIN = 6, PH_GAP = 7, PH_FINISH = 8, PH_DONE = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  conv_writeback_ctrl_v2_if #(.DW(DW), .R(R), .DEPTH_W(DEPTH_W)) bus ();

  conv_writeback_ctrl_v2 #(
    .DW(DW), .R(R), .DEPTH_W(DEPTH_W), .FIFO_DEPTH(FD), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  logic               s_stall, s_start, s_pfe, s_ec, s_ready;
  logic [DEPTH_W-1:0] s_depth;
  logic [RW-1:0]      s_rows;
  logic [R-1:0]       s_rv;
  logic [DW*R-1:0]    s_row;

  int              m_phase, m_remain, m_k, m_n, m_d;
  logic            m_odd, m_ec, m_p_init, m_sc, m_end_op;
  logic [1:0]      m_err;
  logic [R-1:0]    m_pwz;
  logic [DW-1:0]   m_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lowest_row(input logic [R-1:0] rv, input logic [DW*R-1:0] rd);
    for (int i = 0; i < R; i++) begin
      if (rv[i]) return rd[i*DW +: DW];
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_remain = 0; m_k = 0; m_n = R; m_d = 1;
    m_odd = 0; m_ec = 0; m_p_init = 0; m_sc = 0; m_end_op = 0;
    m_err = 2'b00; m_pwz = '0;
    m_q.delete();
  endtask

  task automatic enter(input int ph, input int len);
    m_phase = ph;
    m_remain = len;
  endtask

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    bit empty_before, ec_old, pop, push;
    empty_before = (m_q.size() == 0);
    ec_old = m_ec;
    pop = (m_q.size() > 0) && s_ready;
    push = !s_stall && (s_rv != '0);
    if (m_phase == PH_IDLE && s_start && !s_stall) m_err = 2'b00;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if ($countones(s_rv) > 1) m_err[0] = 1'b1;
      if (m_q.size() >= FD) m_err[1] = 1'b1;
      else m_q.push_back(lowest_row(s_rv, s_row));
    end
    if (m_phase == PH_FINISH) m_ec = 1'b0;
    else if (s_ec) m_ec = 1'b1;
    if (!s_stall) begin
      m_p_init = (m_phase == PH_INIT);
      m_sc = (m_phase == PH_START) || (m_phase == PH_SWAP);
      m_pwz = (m_phase == PH_DRAIN) ? (R'(1) << m_k) : '0;
      m_end_op = (m_phase == PH_DONE);
      if (m_phase == PH_SWAP) m_odd = ~m_odd;
      case (m_phase)
        PH_IDLE: if (s_start) begin
          m_d = (s_depth == 0) ? 1 : int'(s_depth);
          m_n = (s_rows == 0 || s_rows > R) ? R : int'(s_rows);
          enter(PH_INIT, m_d);
        end
        PH_INIT: begin m_remain--; if (m_remain == 0) enter(PH_START, 4); end
        PH_START: begin m_remain--; if (m_remain == 0) enter(PH_WFILT, 0); end
        PH_WFILT: if (s_pfe) enter(PH_WADD, m_d);
        PH_WADD: begin m_remain--; if (m_remain == 0) enter(PH_SWAP, 1); end
        PH_SWAP: enter(PH_DRAIN, m_d);
        PH_DRAIN: begin
          m_remain--;
          if (m_remain == 0) begin
            if (m_k == m_n - 1) begin
              m_k = 0;
              enter(ec_old ? PH_FINISH : PH_WFILT, 0);
            end else begin
              m_k++;
              enter(PH_GAP, 1);
            end
          end
        end
        PH_GAP: enter(PH_DRAIN, m_d);
        PH_FINISH: if (empty_before) enter(PH_DONE, 1);
        PH_DONE: enter(PH_IDLE, 0);
        default: enter(PH_IDLE, 0);
      endcase
    end
  endtask

  task automatic check_output();
    logic [DW-1:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : '0;
    chk("p_init", bus.p_init, m_p_init);
    chk("start_conv", bus.start_conv, m_sc);
    chk("p_write_zero", bus.p_write_zero, m_pwz);
    chk("odd_cnt", bus.odd_cnt, m_odd);
    chk("end_op", bus.end_op, m_end_op);
    chk("busy", bus.busy, m_phase != PH_IDLE);
    chk("err", bus.err, m_err);
    chk("out_valid", bus.out_valid, m_q.size() > 0);
    chk("out_data", bus.out_data, exp_data);
    chk("stall_req", bus.stall_req, m_q.size() >= FD - AFM);
  endtask

  // Drive the staged inputs, step the model, then compare after the clock edge
  task automatic apply_stimulus();
    bus.stall = s_stall; bus.start_init = s_start; bus.cfg_depth = s_depth;
    bus.cfg_rows = s_rows; bus.p_filter_end = s_pfe; bus.end_conv = s_ec;
    bus.row_valid = s_rv; bus.row = s_row; bus.out_ready = s_ready;
    model_step();
    @(negedge clk);
    check_output();
  endtask

  task automatic idle_inputs();
    s_stall = 0; s_start = 0; s_pfe = 0; s_ec = 0; s_ready = 0;
    s_rv = '0; s_row = '0; s_depth = 8'd4; s_rows = 4'd2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bounded safety net in case a scenario never converges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c_pi, c_sc, c_w1, c_w2, c_eo;
    bit found;
    idle_inputs();
    bus.stall = 0; bus.start_init = 0; bus.cfg_depth = '0; bus.cfg_rows = '0;
    bus.p_filter_end = 0; bus.end_conv = 0; bus.row_valid = '0; bus.row = '0;
    bus.out_ready = 0;
    #1;
    do_reset();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_pwz", bus.p_write_zero, 14'd0);

    // Full op D=4 N=2 with filter end ten cycles after start
    idle_inputs(); s_ec = 1; s_ready = 1;
    c_pi = 0; c_sc = 0; c_w1 = 0; c_w2 = 0; c_eo = 0;
    for (int t = 0; t < 60; t++) begin
      s_start = (t == 0);
      s_pfe = (t == 10);
      apply_stimulus();
      if (bus.p_init) c_pi++;
      if (bus.start_conv) c_sc++;
      if (bus.p_write_zero == 14'd1) c_w1++;
      if (bus.p_write_zero == 14'd2) c_w2++;
      if (bus.end_op) c_eo++;
    end
    chk("t1_p_init_cycles", c_pi, 4);
    chk("t1_start_conv_cycles", c_sc, 5);
    chk("t1_pwz_row0_cycles", c_w1, 4);
    chk("t1_pwz_row1_cycles", c_w2, 4);
    chk("t1_end_op_pulses", c_eo, 1);
    chk("t1_odd_cnt_final", bus.odd_cnt, 1'b1);
    chk("t1_idle_after", bus.busy, 1'b0);

    // Single push from row 2 becomes visible one cycle later
    do_reset(); idle_inputs();
    s_rv = 14'b00_0000_0000_0100;
    s_row[2*DW +: DW] = 32'hA5A5; s_row[0 +: DW] = 32'h1234;
    s_ready = 1;
    apply_stimulus();
    chk("t2_out_valid", bus.out_valid, 1'b1);
    chk("t2_out_data", bus.out_data, 32'hA5A5);
    s_rv = '0;
    apply_stimulus();
    chk("t2_drained", bus.out_valid, 1'b0);

    // Fill without draining: almost-full at 12, overflow at 17, order preserved
    do_reset(); idle_inputs();
    for (int i = 0; i < 17; i++) begin
      s_row = '0;
      s_rv = R'(1) << (i % R);
      s_row[(i % R)*DW +: DW] = 32'h100 + i;
      apply_stimulus();
      if (i == 10) chk("t3_stall_req_at_11", bus.stall_req, 1'b0);
      if (i == 11) chk("t3_stall_req_at_12", bus.stall_req, 1'b1);
      if (i == 15) chk("t3_err_before_overflow", bus.err, 2'b00);
    end
    chk("t3_err_overflow", bus.err, 2'b10);
    s_rv = '0; s_ready = 1;
    for (int j = 0; j < 16; j++) begin
      chk("t3_fifo_order", bus.out_data, 32'h100 + j);
      apply_stimulus();
    end
    chk("t3_empty", bus.out_valid, 1'b0);

    // Two rows valid at once: lowest wins, err[0] set, cleared by next start
    do_reset(); idle_inputs();
    s_rv = 14'b00_0000_0000_0110;
    s_row[1*DW +: DW] = 32'h1111; s_row[2*DW +: DW] = 32'h2222;
    apply_stimulus();
    chk("t4_lowest_row", bus.out_data, 32'h1111);
    chk("t4_err_multi", bus.err, 2'b01);
    s_rv = '0; s_start = 1; s_depth = 8'd2; s_rows = 4'd1;
    apply_stimulus();
    chk("t4_err_cleared", bus.err, 2'b00);
    chk("t4_busy", bus.busy, 1'b1);

    // Five-cycle stall in the middle of a drain
    do_reset(); idle_inputs();
    s_ec = 1; s_pfe = 1; s_ready = 1;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      s_start = (t == 0);
      apply_stimulus();
      if (bus.p_write_zero == 14'd1) found = 1;
    end
    chk("t5_reach_drain", found, 1'b1);
    c_w1 = 1;
    s_stall = 1;
    for (int t = 0; t < 5; t++) begin
      apply_stimulus();
      chk("t5_pwz_frozen", bus.p_write_zero, 14'd1);
      if (bus.p_write_zero == 14'd1) c_w1++;
    end
    s_stall = 0;
    for (int t = 0; t < 20; t++) begin
      apply_stimulus();
      if (bus.p_write_zero == 14'd1) c_w1++;
    end
    chk("t5_drain_len_with_stall", c_w1, 9);

    // Reset in the middle of draining row 1, then a clean op
    do_reset(); idle_inputs();
    s_pfe = 1; s_ready = 1;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      s_start = (t == 0);
      apply_stimulus();
      if (bus.p_write_zero == 14'd2) found = 1;
    end
    chk("t6_reach_row1", found, 1'b1);
    do_reset();
    chk("t6_busy_cleared", bus.busy, 1'b0);
    chk("t6_pwz_cleared", bus.p_write_zero, 14'd0);
    chk("t6_odd_cleared", bus.odd_cnt, 1'b0);
    idle_inputs(); s_pfe = 1; s_ec = 1; s_ready = 1; s_depth = 8'd3; s_rows = 4'd1;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      s_start = (t == 0);
      apply_stimulus();
      if (bus.end_op) found = 1;
    end
    chk("t6_clean_op_end", found, 1'b1);

    // Long randomized run against the model
    do_reset(); idle_inputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      if ($urandom_range(799) == 0) begin
        do_reset();
      end else begin
        s_stall = ($urandom_range(9) == 0);
        s_start = ($urandom_range(3) == 0);
        s_depth = DEPTH_W'($urandom_range(6));
        s_rows = RW'($urandom_range(15));
        s_pfe = ($urandom_range(4) == 0);
        s_ec = ($urandom_range(11) == 0);
        r = $urandom_range(9);
        if (r < 5) s_rv = '0;
        else if (r == 8) s_rv = R'($urandom);
        else s_rv = R'(1) << $urandom_range(R - 1);
        for (int i = 0; i < R; i++) s_row[i*DW +: DW] = $urandom;
        if ((cyc / 500) % 2 == 0) s_ready = ($urandom_range(9) < 8);
        else s_ready = ($urandom_range(9) < 2);
        apply_stimulus();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
